int_sched: RTL
==============

INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all PC/address/CSR data ports.
REQ-002 Parameter MTVEC_RST, default 32'h0000_0100: reset value of mtvec.
REQ-003 clk_i  in  1: single clock, rising edge.
REQ-004 rst_n_i  in  1: asynchronous reset, active-low.
REQ-005 timer_irq_i  in  1: level timer interrupt from hwtimer.
REQ-006 ext_irq_i  in  1: level external interrupt.
REQ-007 stall_i  in  1: OR of pipeline stall vector; high means the pipeline is stalled.
REQ-008 jump_we_i  in  1: jump/branch redirect resolved in EXE this cycle.
REQ-009 pc_i  in  ADDR_WIDTH: PC of the oldest live instruction, from the pipeline controller.
REQ-010 mret_i  in  1: EXE stage holds an mret, one-cycle pulse.
REQ-011 csr_we_i  in  1: CSR write strobe.
REQ-012 csr_waddr_i  in  12, csr_wdata_i  in  ADDR_WIDTH: CSR write address and data.
REQ-013 csr_raddr_i  in  12, csr_rdata_o  out  ADDR_WIDTH: combinational CSR read; returns 0 for unmapped addresses.
REQ-014 int_en_o  out  1: one-cycle redirect/flush request to the pipeline controller.
REQ-015 isr_pc_o  out  ADDR_WIDTH: redirect target, valid while int_en_o is high.

Function
REQ-016 CSRs: mstatus 0x300 (bit3 MIE, bit7 MPIE, other bits read 0), mie 0x304 (bit7 MTIE, bit11 MEIE), mtvec 0x305 (bits[1:0] forced to 0), mepc 0x341 (bits[1:0] forced to 0), mcause 0x342, mip 0x344 (read-only: bit7 = timer_irq_i, bit11 = ext_irq_i).
REQ-017 pending = MIE & ((MEIE & ext_irq_i) | (MTIE & timer_irq_i)); external has priority over timer.
REQ-018 FSM states: IDLE, WAIT, ENTER, BUSY, RET.
REQ-019 IDLE: mret_i -> RET; else pending & !stall_i & !jump_we_i -> ENTER; else pending -> WAIT.
REQ-020 WAIT: !pending -> IDLE (interrupt withdrawn); else !stall_i & !jump_we_i -> ENTER; else stay.
REQ-021 ENTER lasts one cycle: int_en_o = 1, isr_pc_o = mtvec; on exit mepc <= pc_i sampled in ENTER, mcause <= 32'h8000_000B (ext) or 32'h8000_0007 (timer), MPIE <= MIE, MIE <= 0; next state BUSY.
REQ-022 BUSY: mret_i -> RET; else pending (software re-enabled MIE) & !stall_i & !jump_we_i -> ENTER; else pending -> WAIT; else stay.
REQ-023 RET lasts one cycle: int_en_o = 1, isr_pc_o = mepc; on exit MIE <= MPIE, MPIE <= 1; next state IDLE.
REQ-024 int_en_o and isr_pc_o are Moore outputs decoded from state only; isr_pc_o = 0 in IDLE, WAIT and BUSY.
REQ-025 Latency: pending with a quiet pipeline in cycle N gives int_en_o high in cycle N+1; mret_i in cycle N gives int_en_o high in cycle N+1.
REQ-026 mret_i and pending in the same cycle: mret_i wins; the interrupt is re-evaluated after RET.
REQ-027 A CSR write takes effect on the next edge; in ENTER/RET the hardware updates of mstatus, mepc and mcause take priority over a same-cycle software write to the same CSR.
REQ-028 mret_i in WAIT, ENTER or RET is ignored.

Reset
REQ-029 While rst_n_i is low: state = IDLE, int_en_o = 0, isr_pc_o = 0, mstatus = 0, mie = 0, mtvec = MTVEC_RST, mepc = 0, mcause = 0.
REQ-030 Reset asserted mid-ENTER or mid-RET aborts immediately; no CSR update from that state is retained.

Verification
REQ-031 Set MIE=1 and MTIE=1; raise timer_irq_i with stall_i=0 and pc_i=0x0000_0040 -> next cycle int_en_o=1 and isr_pc_o=0x100; afterwards mepc=0x40, mcause=0x8000_0007, MIE=0, MPIE=1.
REQ-032 Same as REQ-031 but hold stall_i=1 for 3 cycles -> FSM sits in WAIT and int_en_o stays 0; int_en_o pulses in the cycle after stall_i falls.
REQ-033 From BUSY, pulse mret_i -> next cycle int_en_o=1 and isr_pc_o=0x40; afterwards MIE=1 and state=IDLE.
REQ-034 Raise ext_irq_i and timer_irq_i together with both enabled -> mcause=0x8000_000B; the timer is taken after the subsequent mret.
REQ-035 Write mtvec=0x203 and mepc=0x87 -> read back 0x200 and 0x84; read mip with both IRQs high -> 0x880.
REQ-036 Drop rst_n_i during ENTER -> int_en_o=0 immediately; after release all CSRs hold their reset values and state=IDLE.

Source files
------------

// File: rtl/int_sched.sv
// Machine-mode interrupt scheduler: owns the trap CSRs and asks the pipeline
// controller to redirect fetch on interrupt entry and on mret.
module int_sched #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MTVEC_RST  = 32'h0000_0100
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  timer_irq_i,
    input  logic                  ext_irq_i,
    input  logic                  stall_i,
    input  logic                  jump_we_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  mret_i,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [ADDR_WIDTH-1:0] csr_wdata_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [ADDR_WIDTH-1:0] csr_rdata_o,
    // int_en_o is a one-cycle redirect request with isr_pc_o valid alongside it;
    // the pipeline controller has no back-pressure, so there is no ready signal.
    output logic                  int_en_o,
    output logic [ADDR_WIDTH-1:0] isr_pc_o,
    // Debug view of the FSM: 0 IDLE, 1 WAIT, 2 ENTER, 3 BUSY, 4 RET.
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ENTER = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RET   = 3'd4
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [ADDR_WIDTH-1:0] CAUSE_EXT  = {1'b1, {(ADDR_WIDTH-5){1'b0}}, 4'hB};
    localparam logic [ADDR_WIDTH-1:0] CAUSE_TMR  = {1'b1, {(ADDR_WIDTH-5){1'b0}}, 4'h7};

    state_t                r_state;
    state_t                w_next;
    logic                  r_mie;
    logic                  r_mpie;
    logic                  r_mtie;
    logic                  r_meie;
    logic [ADDR_WIDTH-1:0] r_mtvec;
    logic [ADDR_WIDTH-1:0] r_mepc;
    logic [ADDR_WIDTH-1:0] r_mcause;
    logic                  w_ext_take;
    logic                  w_pending;
    logic                  w_quiet;

    assign w_ext_take  = r_meie & ext_irq_i;
    assign w_pending   = r_mie & (w_ext_take | (r_mtie & timer_irq_i));
    assign w_quiet     = ~stall_i & ~jump_we_i;
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mret_i)                    w_next = ST_RET;
                else if (w_pending && w_quiet) w_next = ST_ENTER;
                else if (w_pending)            w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_pending)   w_next = ST_IDLE;
                else if (w_quiet) w_next = ST_ENTER;
            end
            ST_ENTER: w_next = ST_BUSY;
            ST_BUSY: begin
                if (mret_i)                    w_next = ST_RET;
                else if (w_pending && w_quiet) w_next = ST_ENTER;
                else if (w_pending)            w_next = ST_WAIT;
            end
            ST_RET:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Hardware trap updates are written after the software write so they win.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtie   <= 1'b0;
            r_meie   <= 1'b0;
            r_mtvec  <= MTVEC_RST;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            if (csr_we_i) begin
                case (csr_waddr_i)
                    CSR_MSTATUS: begin
                        r_mie  <= csr_wdata_i[3];
                        r_mpie <= csr_wdata_i[7];
                    end
                    CSR_MIE: begin
                        r_mtie <= csr_wdata_i[7];
                        r_meie <= csr_wdata_i[11];
                    end
                    CSR_MTVEC:  r_mtvec  <= csr_wdata_i & ALIGN_MASK;
                    CSR_MEPC:   r_mepc   <= csr_wdata_i & ALIGN_MASK;
                    CSR_MCAUSE: r_mcause <= csr_wdata_i;
                    default: ;
                endcase
            end
            if (r_state == ST_ENTER) begin
                r_mepc   <= pc_i & ALIGN_MASK;
                r_mcause <= w_ext_take ? CAUSE_EXT : CAUSE_TMR;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (r_state == ST_RET) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[3] = r_mie;
                csr_rdata_o[7] = r_mpie;
            end
            CSR_MIE: begin
                csr_rdata_o[7]  = r_mtie;
                csr_rdata_o[11] = r_meie;
            end
            CSR_MTVEC:  csr_rdata_o = r_mtvec;
            CSR_MEPC:   csr_rdata_o = r_mepc;
            CSR_MCAUSE: csr_rdata_o = r_mcause;
            CSR_MIP: begin
                csr_rdata_o[7]  = timer_irq_i;
                csr_rdata_o[11] = ext_irq_i;
            end
            default: csr_rdata_o = '0;
        endcase
    end

    always_comb begin
        int_en_o = 1'b0;
        isr_pc_o = '0;
        case (r_state)
            ST_ENTER: begin
                int_en_o = 1'b1;
                isr_pc_o = r_mtvec;
            end
            ST_RET: begin
                int_en_o = 1'b1;
                isr_pc_o = r_mepc;
            end
            default: ;
        endcase
    end

endmodule
